// File: rtl/control_unit_pkg.sv
// Shared definitions for the toy-processor control unit: opcodes, ALU function codes,
// sequencer states, instruction field positions and the decoded control bundle.
package control_unit_pkg;

    localparam int INSTR_W  = 16;
    localparam int IR_OP_HI = 15;
    localparam int IR_OP_LO = 12;
    localparam int IR_DR_HI = 11;
    localparam int IR_DR_LO = 9;
    localparam int IR_SA_HI = 8;
    localparam int IR_SA_LO = 6;
    localparam int IR_SB_HI = 5;
    localparam int IR_SB_LO = 3;
    localparam int IMM_W    = 6;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
        OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_SLL  = 4'h6, OP_SRL  = 4'h7,
        OP_ADDI = 4'h8, OP_LW   = 4'h9, OP_SW   = 4'hA, OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC, OP_JMP  = 4'hD, OP_MOV  = 4'hE, OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        FS_ADD = 3'd0, FS_SUB = 3'd1, FS_AND = 3'd2, FS_OR    = 3'd3,
        FS_XOR = 3'd4, FS_SLL = 3'd5, FS_SRL = 3'd6, FS_PASSA = 3'd7
    } fs_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef struct packed {
        fs_e  fs;
        logic mb;
        logic md;
        logic wb_en;
        logic is_mem;
        logic is_br;
        logic is_jmp;
        logic is_halt;
    } ctrl_t;

    // BEQ branches on equal (Z=1), BNE on not-equal (Z=0); SA-SB drives Z.
    function automatic logic branch_taken(input opcode_e op, input logic z);
        return ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational instruction decoder: IR -> ALU function, operand/writeback sources
// and instruction-class flags used by the sequencer.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  logic [INSTR_W-1:0] i_ir,
    output ctrl_t              o_ctrl
);

    opcode_e w_op;

    assign w_op = opcode_e'(i_ir[IR_OP_HI:IR_OP_LO]);

    always_comb begin
        o_ctrl = '0;
        case (w_op)
            OP_ADD:  begin o_ctrl.fs = FS_ADD; o_ctrl.wb_en = 1'b1; end
            OP_SUB:  begin o_ctrl.fs = FS_SUB; o_ctrl.wb_en = 1'b1; end
            OP_AND:  begin o_ctrl.fs = FS_AND; o_ctrl.wb_en = 1'b1; end
            OP_OR:   begin o_ctrl.fs = FS_OR;  o_ctrl.wb_en = 1'b1; end
            OP_XOR:  begin o_ctrl.fs = FS_XOR; o_ctrl.wb_en = 1'b1; end
            OP_SLL:  begin o_ctrl.fs = FS_SLL; o_ctrl.wb_en = 1'b1; end
            OP_SRL:  begin o_ctrl.fs = FS_SRL; o_ctrl.wb_en = 1'b1; end
            OP_ADDI: begin o_ctrl.fs = FS_ADD; o_ctrl.mb = 1'b1; o_ctrl.wb_en = 1'b1; end
            // Loads and stores use the ALU to form SA+imm as the memory address.
            OP_LW: begin
                o_ctrl.fs     = FS_ADD;
                o_ctrl.mb     = 1'b1;
                o_ctrl.md     = 1'b1;
                o_ctrl.wb_en  = 1'b1;
                o_ctrl.is_mem = 1'b1;
            end
            OP_SW:   begin o_ctrl.fs = FS_ADD; o_ctrl.mb = 1'b1; o_ctrl.is_mem = 1'b1; end
            OP_BEQ,
            OP_BNE:  begin o_ctrl.fs = FS_SUB; o_ctrl.is_br = 1'b1; end
            OP_JMP:  begin o_ctrl.fs = FS_PASSA; o_ctrl.is_jmp = 1'b1; end
            OP_MOV:  begin o_ctrl.fs = FS_PASSA; o_ctrl.wb_en = 1'b1; end
            OP_HALT: o_ctrl.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the toy processor: holds PC and IR, steps
// FETCH/DECODE/EXECUTE/[MEM]/WRITEBACK and drives register file, ALU and memory controls.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DATA_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_z,
    input  logic [DATA_W-1:0]  i_data_a,
    input  logic               i_mem_ready,
    output logic [PC_W-1:0]    o_pc,
    output logic [2:0]         o_sa,
    output logic [2:0]         o_sb,
    output logic [2:0]         o_dr,
    output logic               o_ld,
    output logic [2:0]         o_fs,
    output logic               o_mb,
    output logic [DATA_W-1:0]  o_imm,
    output logic               o_md,
    output logic               o_mw,
    output logic               o_mr,
    output logic               o_halted
);

    state_e             r_state;
    state_e             w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0] r_ir;
    ctrl_t              w_ctrl;
    opcode_e            w_op;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_pc_br;

    control_unit_decode u_decode (
        .i_ir   (r_ir),
        .o_ctrl (w_ctrl)
    );

    assign w_op     = opcode_e'(r_ir[IR_OP_HI:IR_OP_LO]);
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_br  = w_pc_inc + {{(PC_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == ST_FETCH) begin
                r_ir <= i_instr;
            end
        end
    end

    // PC moves only on the edge that retires the instruction.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = ST_EXECUTE;
            ST_EXECUTE: begin
                if (w_ctrl.is_halt) begin
                    w_state_next = ST_HALT;
                end else if (w_ctrl.is_mem) begin
                    w_state_next = ST_MEM;
                end else if (w_ctrl.wb_en) begin
                    w_state_next = ST_WRITEBACK;
                end else begin
                    w_state_next = ST_FETCH;
                    if (w_ctrl.is_jmp) begin
                        w_pc_next = i_data_a[PC_W-1:0];
                    end else if (w_ctrl.is_br && branch_taken(w_op, i_z)) begin
                        w_pc_next = w_pc_br;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
            ST_MEM: begin
                if (i_mem_ready) begin
                    if (w_ctrl.wb_en) begin
                        w_state_next = ST_WRITEBACK;
                    end else begin
                        w_state_next = ST_FETCH;
                        w_pc_next    = w_pc_inc;
                    end
                end
            end
            ST_WRITEBACK: begin
                w_state_next = ST_FETCH;
                w_pc_next    = w_pc_inc;
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_FETCH;
        endcase
    end

    assign o_pc     = r_pc;
    assign o_sa     = r_ir[IR_SA_HI:IR_SA_LO];
    assign o_sb     = r_ir[IR_SB_HI:IR_SB_LO];
    assign o_dr     = r_ir[IR_DR_HI:IR_DR_LO];
    assign o_fs     = w_ctrl.fs;
    assign o_mb     = w_ctrl.mb;
    assign o_md     = w_ctrl.md;
    assign o_imm    = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
    assign o_ld     = (r_state == ST_WRITEBACK);
    assign o_mr     = (r_state == ST_MEM) && (w_op == OP_LW);
    assign o_mw     = (r_state == ST_MEM) && (w_op == OP_SW);
    assign o_halted = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an ISA-level model predicts latency, next PC,
// control pulses and decoded fields for each instruction; observations are compared on retire.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_instr;
    logic        i_z;
    logic [7:0]  i_data_a;
    logic        i_mem_ready;
    logic [7:0]  o_pc;
    logic [2:0]  o_sa, o_sb, o_dr, o_fs;
    logic        o_ld, o_mb, o_md, o_mw, o_mr, o_halted;
    logic [7:0]  o_imm;

    always #5 clk = ~clk;

    control_unit #(.PC_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_instr     (i_instr),
        .i_z         (i_z),
        .i_data_a    (i_data_a),
        .i_mem_ready (i_mem_ready),
        .o_pc        (o_pc),
        .o_sa        (o_sa),
        .o_sb        (o_sb),
        .o_dr        (o_dr),
        .o_ld        (o_ld),
        .o_fs        (o_fs),
        .o_mb        (o_mb),
        .o_imm       (o_imm),
        .o_md        (o_md),
        .o_mw        (o_mw),
        .o_mr        (o_mr),
        .o_halted    (o_halted)
    );

    typedef struct {
        int         lat;
        logic [7:0] pc;
        int         ld;
        int         mr;
        int         mw;
        logic [2:0] dr, sa, sb, fs;
        logic       mb;
        logic [7:0] imm;
        logic       md;
        bit         chk_fs;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] dr,
                                          input logic [2:0] sa, input logic [2:0] sb);
        return {op, dr, sa, sb, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] dr,
                                          input logic [2:0] sa, input logic [5:0] imm6);
        return {op, dr, sa, imm6};
    endfunction

    function automatic exp_t model(input logic [15:0] ins, input logic [7:0] pc,
                                   input logic z, input logic [7:0] da, input int w);
        exp_t       e;
        logic [3:0] op;
        op       = ins[15:12];
        e.dr     = ins[11:9];
        e.sa     = ins[8:6];
        e.sb     = ins[5:3];
        e.imm    = {{2{ins[5]}}, ins[5:0]};
        e.md     = (op == 4'h9);
        e.mb     = (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
        e.chk_fs = (op != 4'h0) && (op != 4'hD) && (op != 4'hF);
        if (op >= 4'h1 && op <= 4'h7)      e.fs = 3'(op - 4'h1);
        else if (op == 4'hB || op == 4'hC) e.fs = 3'd1;
        else if (op == 4'hE)               e.fs = 3'd7;
        else                               e.fs = 3'd0;
        e.ld = ((op >= 4'h1 && op <= 4'h9) || op == 4'hE) ? 1 : 0;
        e.mr = (op == 4'h9) ? w + 1 : 0;
        e.mw = (op == 4'hA) ? w + 1 : 0;
        if (op == 4'h9)      e.lat = 5 + w;
        else if (op == 4'hA) e.lat = 4 + w;
        else if (op == 4'h0 || op == 4'hB || op == 4'hC || op == 4'hD) e.lat = 3;
        else                 e.lat = 4;
        if (op == 4'hD)                     e.pc = da;
        else if ((op == 4'hB && z) || (op == 4'hC && !z)) e.pc = pc + 8'd1 + e.imm;
        else                                e.pc = pc + 8'd1;
        return e;
    endfunction

    // Called while the DUT sits in FETCH; returns once the PC has moved (next FETCH).
    task automatic run_instr(input string tag, input logic [15:0] ins, input logic z,
                             input logic [7:0] da, input int w, input bit rdy_always);
        exp_t       e;
        int         cyc, ld, mr, mw, memk, multi;
        logic [7:0] pc0;
        logic [2:0] sa1, sb1, dr1, fs1;
        logic       mb1, md_ld;
        logic [7:0] imm1;
        cyc = 0; ld = 0; mr = 0; mw = 0; memk = 0; multi = 0;
        sa1 = 'x; sb1 = 'x; dr1 = 'x; fs1 = 'x; mb1 = 'x; imm1 = 'x; md_ld = 'x;
        pc0 = o_pc;
        sb_q.push_back(model(ins, pc0, z, da, w));
        i_instr = ins; i_z = z; i_data_a = da; i_mem_ready = rdy_always;
        while (o_pc == pc0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                sa1 = o_sa; sb1 = o_sb; dr1 = o_dr; fs1 = o_fs; mb1 = o_mb; imm1 = o_imm;
            end
            if (o_ld) begin ld++; md_ld = o_md; end
            if (o_mr) mr++;
            if (o_mw) mw++;
            if (int'(o_ld) + int'(o_mr) + int'(o_mw) > 1) multi++;
            if (o_mr || o_mw) begin
                memk++;
                i_mem_ready = rdy_always || (memk > w);
            end else begin
                i_mem_ready = rdy_always;
            end
        end
        e = sb_q.pop_front();
        check_eq({tag, " lat"}, cyc, e.lat);
        check_eq({tag, " pc"}, o_pc, e.pc);
        check_eq({tag, " ld"}, ld, e.ld);
        check_eq({tag, " mr"}, mr, e.mr);
        check_eq({tag, " mw"}, mw, e.mw);
        check_eq({tag, " excl"}, multi, 0);
        check_eq({tag, " sa"}, sa1, e.sa);
        check_eq({tag, " sb"}, sb1, e.sb);
        check_eq({tag, " dr"}, dr1, e.dr);
        check_eq({tag, " imm"}, imm1, e.imm);
        if (e.chk_fs) begin
            check_eq({tag, " fs"}, fs1, e.fs);
            check_eq({tag, " mb"}, mb1, e.mb);
        end
        if (e.ld > 0) check_eq({tag, " md"}, md_ld, e.md);
        $display("instr %-8s %h pc %h->%h lat %0d ld %0d mr %0d mw %0d",
                 tag, ins, pc0, o_pc, cyc, ld, mr, mw);
    endtask

    initial begin
        i_reset = 1'b1; i_instr = 16'h0000; i_z = 1'b0; i_data_a = 8'h00; i_mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b0;
        check_eq("rst pc", o_pc, 8'h00);
        check_eq("rst ld/mw/mr/halt", {o_ld, o_mw, o_mr, o_halted}, 4'b0000);
        check_eq("rst selects", {o_sa, o_sb, o_dr, o_fs}, 12'h000);
        $display("reset released pc %h", o_pc);

        for (int i = 0; i < 3; i++) run_instr("nop", 16'h0000, 1'b0, 8'h00, 0, 1'b0);
        run_instr("add", enc_r(4'h1, 3'd1, 3'd2, 3'd4), 1'b0, 8'h00, 0, 1'b0);
        for (int op = 2; op <= 7; op++)
            run_instr("alu", enc_r(4'(op), 3'(op), 3'(op + 1), 3'(7 - op)), 1'b1, 8'h00, 0, 1'b0);
        run_instr("addi", enc_i(4'h8, 3'd7, 3'd3, 6'h3B), 1'b0, 8'h00, 0, 1'b0);
        run_instr("mov", enc_r(4'hE, 3'd5, 3'd6, 3'd0), 1'b0, 8'h00, 0, 1'b0);
        run_instr("lw", enc_i(4'h9, 3'd2, 3'd1, 6'h03), 1'b0, 8'h00, 3, 1'b0);
        run_instr("sw_rdy", enc_i(4'hA, 3'd0, 3'd4, 6'h3F), 1'b0, 8'h00, 0, 1'b1);
        run_instr("sw_w1", enc_i(4'hA, 3'd0, 3'd2, 6'h30), 1'b0, 8'h00, 1, 1'b0);

        run_instr("jmp", enc_r(4'hD, 3'd0, 3'd3, 3'd0), 1'b0, 8'h05, 0, 1'b0);
        run_instr("beq_t", enc_i(4'hB, 3'd0, 3'd1, 6'h3E), 1'b1, 8'h00, 0, 1'b0);
        run_instr("jmp", enc_r(4'hD, 3'd0, 3'd3, 3'd0), 1'b0, 8'h05, 0, 1'b0);
        run_instr("beq_nt", enc_i(4'hB, 3'd0, 3'd1, 6'h3E), 1'b0, 8'h00, 0, 1'b0);
        run_instr("bne_t", enc_i(4'hC, 3'd0, 3'd2, 6'h03), 1'b0, 8'h00, 0, 1'b0);
        run_instr("bne_nt", enc_i(4'hC, 3'd0, 3'd2, 6'h03), 1'b1, 8'h00, 0, 1'b0);
        run_instr("jmp", enc_r(4'hD, 3'd0, 3'd3, 3'd0), 1'b0, 8'hFE, 0, 1'b0);
        run_instr("beq_wrap", enc_i(4'hB, 3'd0, 3'd1, 6'h01), 1'b1, 8'h00, 0, 1'b0);
        run_instr("jmp", enc_r(4'hD, 3'd0, 3'd3, 3'd0), 1'b0, 8'hFF, 0, 1'b0);
        run_instr("nop_wrap", 16'h0000, 1'b0, 8'h00, 0, 1'b0);

        // Reset while a store waits in MEM.
        run_instr("jmp", enc_r(4'hD, 3'd0, 3'd3, 3'd0), 1'b0, 8'h40, 0, 1'b0);
        i_instr = enc_i(4'hA, 3'd0, 3'd4, 6'h02);
        i_mem_ready = 1'b0;
        for (int i = 0; i < 10 && !o_mw; i++) begin
            @(posedge clk); #1;
        end
        check_eq("sw mw seen", o_mw, 1'b1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        check_eq("rst_mem mw", o_mw, 1'b0);
        check_eq("rst_mem ld", o_ld, 1'b0);
        check_eq("rst_mem pc", o_pc, 8'h00);
        $display("reset during SW MEM: pc %h mw %b", o_pc, o_mw);
        run_instr("nop_post", 16'h0000, 1'b0, 8'h00, 0, 1'b0);

        // HALT at pc 1
        i_instr = 16'hF000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("halt exec", o_halted, 1'b0);
        @(posedge clk); #1;
        check_eq("halt entered", o_halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            i_mem_ready = i[0];
            @(posedge clk); #1;
            check_eq("halt pc", o_pc, 8'h01);
            check_eq("halt ctl", {o_halted, o_ld, o_mr, o_mw}, 4'b1000);
        end
        $display("halt held 20 cycles pc %h halted %b", o_pc, o_halted);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        check_eq("halt rst halted", o_halted, 1'b0);
        check_eq("halt rst pc", o_pc, 8'h00);
        run_instr("add_post", enc_r(4'h1, 3'd0, 3'd7, 3'd6), 1'b0, 8'h00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
